// File: rtl/fft_r2_stage.sv
// Radix-2 DIF FFT stage: latches one N-point frame, runs NUM_BF butterflies per cycle in place, presents the frame.
// Optional build macro FFT_R2_STAGE_SAT_EN selects saturating (instead of wrapping) output reduction.
module fft_r2_stage #(
  parameter int DATA_WIDTH = 20,
  parameter int N_POINTS   = 16,
  parameter int STAGE      = 0,
  parameter int TW_WIDTH   = 20,
  parameter int NUM_BF     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*N_POINTS-1:0] x_in_flat_real,
  input  logic [DATA_WIDTH*N_POINTS-1:0] x_in_flat_imag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH*N_POINTS-1:0] x_out_flat_real,
  output logic [DATA_WIDTH*N_POINTS-1:0] x_out_flat_imag
);

  localparam int LOG_N    = $clog2(N_POINTS);
  localparam int SPAN     = N_POINTS >> (STAGE + 1);
  localparam int SPAN_LOG = LOG_N - STAGE - 1;
  localparam int CYCLES   = N_POINTS / (2 * NUM_BF);
  localparam int CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int PB_W     = $clog2(DATA_WIDTH * N_POINTS);
  localparam int TWI_W    = LOG_N - 1;
  localparam int PW       = DATA_WIDTH + TW_WIDTH + 2;
  localparam int RW       = DATA_WIDTH + 3;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CYCLES - 1);
  localparam logic signed [PW-1:0] RND    = PW'(64'd1 << (TW_WIDTH - 2));
`ifdef FFT_R2_STAGE_SAT_EN
  localparam logic signed [RW-1:0] SAT_MAX = RW'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
  localparam logic signed [RW-1:0] SAT_MIN = -SAT_MAX - RW'(1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                          r_state;
  logic                            r_in_ready;
  logic                            r_out_valid;
  logic [CNT_W-1:0]                r_cnt;
  logic [DATA_WIDTH*N_POINTS-1:0]  r_re;
  logic [DATA_WIDTH*N_POINTS-1:0]  r_im;

  logic signed [TW_WIDTH-1:0] w_tw_re [N_POINTS/2];
  logic signed [TW_WIDTH-1:0] w_tw_im [N_POINTS/2];
  logic [PB_W-1:0]            w_pa    [NUM_BF];
  logic [PB_W-1:0]            w_pb    [NUM_BF];
  logic [TWI_W-1:0]           w_t     [NUM_BF];
  logic signed [DATA_WIDTH:0] w_d_re  [NUM_BF];
  logic signed [DATA_WIDTH:0] w_d_im  [NUM_BF];
  logic signed [DATA_WIDTH-1:0] w_ya_re [NUM_BF];
  logic signed [DATA_WIDTH-1:0] w_ya_im [NUM_BF];
  logic signed [DATA_WIDTH-1:0] w_yb_re [NUM_BF];
  logic signed [DATA_WIDTH-1:0] w_yb_im [NUM_BF];

  // Elaboration-time twiddle value: cos (is_cos) or -sin of 2*pi*t/N, scaled and rounded to nearest.
  function automatic logic signed [TW_WIDTH-1:0] tw_f(input int t, input logic is_cos);
    real ang;
    real v;
    ang = 2.0 * 3.14159265358979323846 * real'(t) / real'(N_POINTS);
    v   = (is_cos ? $cos(ang) : -$sin(ang)) * (2.0 ** (TW_WIDTH - 1) - 1.0);
    return TW_WIDTH'((v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] reduce(input logic signed [RW-1:0] v);
`ifdef FFT_R2_STAGE_SAT_EN
    if (v > SAT_MAX) begin
      return DATA_WIDTH'(SAT_MAX);
    end else if (v < SAT_MIN) begin
      return DATA_WIDTH'(SAT_MIN);
    end else begin
      return DATA_WIDTH'(v);
    end
`else
    return DATA_WIDTH'(v);
`endif
  endfunction

  function automatic logic signed [DATA_WIDTH:0] ext(input logic [DATA_WIDTH-1:0] v);
    return (DATA_WIDTH + 1)'($signed(v));
  endfunction

  // One component of d*W: p*cp -/+ q*cq, rounded half-up back to Q0 and reduced.
  function automatic logic signed [DATA_WIDTH-1:0] rot_rnd(
    input logic signed [DATA_WIDTH:0]   p,
    input logic signed [DATA_WIDTH:0]   q,
    input logic signed [TW_WIDTH-1:0]   cp,
    input logic signed [TW_WIDTH-1:0]   cq,
    input logic                         sub
  );
    logic signed [PW-1:0] m;
    if (sub) begin
      m = PW'(p) * PW'(cp) - PW'(q) * PW'(cq);
    end else begin
      m = PW'(p) * PW'(cp) + PW'(q) * PW'(cq);
    end
    return reduce(RW'((m + RND) >>> (TW_WIDTH - 1)));
  endfunction

  function automatic int lane_k(input logic [CNT_W-1:0] cnt, input int l);
    return int'(cnt) * NUM_BF + l;
  endfunction

  function automatic int bf_a(input int k);
    return ((k >> SPAN_LOG) << (SPAN_LOG + 1)) + (k & (SPAN - 1));
  endfunction

  // Element e sits at the high end of the flat bus, so its LSB is at DATA_WIDTH*(N-1-e).
  function automatic int el_base(input int e);
    return DATA_WIDTH * (N_POINTS - 1 - e);
  endfunction

  for (genvar t = 0; t < N_POINTS / 2; t++) begin : g_tw
    localparam logic signed [TW_WIDTH-1:0] C_RE = tw_f(t, 1'b1);
    localparam logic signed [TW_WIDTH-1:0] C_IM = tw_f(t, 1'b0);
    assign w_tw_re[t] = C_RE;
    assign w_tw_im[t] = C_IM;
  end

  // Butterfly datapath for the NUM_BF lanes selected by the current counter value.
  always_comb begin
    for (int l = 0; l < NUM_BF; l++) begin
      w_pa[l]    = PB_W'(el_base(bf_a(lane_k(r_cnt, l))));
      w_pb[l]    = PB_W'(el_base(bf_a(lane_k(r_cnt, l)) + SPAN));
      w_t[l]     = TWI_W'((lane_k(r_cnt, l) & (SPAN - 1)) << STAGE);
      w_d_re[l]  = ext(r_re[w_pa[l] +: DATA_WIDTH]) - ext(r_re[w_pb[l] +: DATA_WIDTH]);
      w_d_im[l]  = ext(r_im[w_pa[l] +: DATA_WIDTH]) - ext(r_im[w_pb[l] +: DATA_WIDTH]);
      w_ya_re[l] = reduce(RW'(ext(r_re[w_pa[l] +: DATA_WIDTH]) + ext(r_re[w_pb[l] +: DATA_WIDTH])));
      w_ya_im[l] = reduce(RW'(ext(r_im[w_pa[l] +: DATA_WIDTH]) + ext(r_im[w_pb[l] +: DATA_WIDTH])));
      w_yb_re[l] = rot_rnd(w_d_re[l], w_d_im[l], w_tw_re[w_t[l]], w_tw_im[w_t[l]], 1'b1);
      w_yb_im[l] = rot_rnd(w_d_re[l], w_d_im[l], w_tw_im[w_t[l]], w_tw_re[w_t[l]], 1'b0);
    end
  end

  // Control FSM and in-place frame register; out_valid rises one cycle after the last write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_cnt       <= '0;
      r_re        <= '0;
      r_im        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_re       <= x_in_flat_real;
            r_im       <= x_in_flat_imag;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          for (int l = 0; l < NUM_BF; l++) begin
            r_re[w_pa[l] +: DATA_WIDTH] <= w_ya_re[l];
            r_im[w_pa[l] +: DATA_WIDTH] <= w_ya_im[l];
            r_re[w_pb[l] +: DATA_WIDTH] <= w_yb_re[l];
            r_im[w_pb[l] +: DATA_WIDTH] <= w_yb_im[l];
          end
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

  assign in_ready        = r_in_ready;
  assign out_valid       = r_out_valid;
  assign x_out_flat_real = r_re;
  assign x_out_flat_imag = r_im;

endmodule

// File: tb/tb_fft_r2_stage.sv
// Scoreboard bench for fft_r2_stage (defaults N=16, STAGE=0, NUM_BF=2); honours FFT_R2_STAGE_SAT_EN.
module tb_fft_r2_stage;

  localparam int DW = 20;
  localparam int N  = 16;
  localparam int ST = 0;
  localparam int TW = 20;
  localparam int NB = 2;
  localparam int BW = DW * N;

  typedef logic [BW-1:0] bus_t;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready;
  bus_t x_in_re, x_in_im, x_out_re, x_out_im;

  int   n_checks = 0;
  int   n_errors = 0;
  bus_t q_re[$];
  bus_t q_im[$];

  fft_r2_stage #(.DATA_WIDTH(DW), .N_POINTS(N), .STAGE(ST), .TW_WIDTH(TW), .NUM_BF(NB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in_flat_real(x_in_re), .x_in_flat_imag(x_in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out_flat_real(x_out_re), .x_out_flat_imag(x_out_im)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input bus_t got, input bus_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] get_el(input bus_t b, input int i);
    return b[DW*(N-i)-1 -: DW];
  endfunction

  function automatic bus_t put_el(input bus_t b, input int i, input longint v);
    b[DW*(N-i)-1 -: DW] = DW'(v);
    return b;
  endfunction

  function automatic longint red(input longint v);
    longint m;
`ifdef FFT_R2_STAGE_SAT_EN
    m = v;
    if (v > (longint'(1) << (DW - 1)) - 1) m = (longint'(1) << (DW - 1)) - 1;
    if (v < -(longint'(1) << (DW - 1))) m = -(longint'(1) << (DW - 1));
`else
    m = v % (longint'(1) << DW);
    if (m < 0) m = m + (longint'(1) << DW);
    if (m >= (longint'(1) << (DW - 1))) m = m - (longint'(1) << DW);
`endif
    return m;
  endfunction

  function automatic longint tw(input int t, input bit is_cos);
    real ang, v;
    ang = 2.0 * 3.141592653589793 * t / N;
    v   = is_cos ? $cos(ang) : -$sin(ang);
    v   = v * (2.0 ** (TW - 1) - 1.0);
    return longint'($rtoi($floor(v + 0.5)));
  endfunction

  // Reference butterfly stage over the whole frame, pushed to the scoreboard.
  task automatic push_exp(input bus_t ire, input bus_t iim);
    longint xr[N], xi[N], yr[N], yi[N];
    longint wr, wi, dr, di, rnd;
    int     span, a, b, t;
    bus_t   ore, oim;
    span = N >> (ST + 1);
    rnd  = longint'(1) << (TW - 2);
    for (int i = 0; i < N; i++) begin
      xr[i] = longint'(get_el(ire, i));
      xi[i] = longint'(get_el(iim, i));
    end
    for (int k = 0; k < N / 2; k++) begin
      a  = 2 * (k / span) * span + (k % span);
      b  = a + span;
      t  = (k % span) << ST;
      wr = tw(t, 1'b1);
      wi = tw(t, 1'b0);
      dr = xr[a] - xr[b];
      di = xi[a] - xi[b];
      yr[a] = red(xr[a] + xr[b]);
      yi[a] = red(xi[a] + xi[b]);
      yr[b] = red((dr * wr - di * wi + rnd) >>> (TW - 1));
      yi[b] = red((dr * wi + di * wr + rnd) >>> (TW - 1));
    end
    ore = '0;
    oim = '0;
    for (int i = 0; i < N; i++) begin
      ore = put_el(ore, i, yr[i]);
      oim = put_el(oim, i, yi[i]);
    end
    q_re.push_back(ore);
    q_im.push_back(oim);
  endtask

  function automatic bus_t fill(input longint v);
    bus_t b = '0;
    for (int i = 0; i < N; i++) b = put_el(b, i, v);
    return b;
  endfunction

  function automatic bus_t rnd_bus();
    bus_t b = '0;
    for (int i = 0; i < N; i++) b = put_el(b, i, longint'($urandom));
    return b;
  endfunction

  // Output monitor: every accepted output frame is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q_re.size() == 0) begin
        check_eq("unexpected_frame", bus_t'(out_valid), bus_t'(0));
      end else begin
        check_eq("frame_re", x_out_re, q_re.pop_front());
        check_eq("frame_im", x_out_im, q_im.pop_front());
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic send(input bus_t re, input bus_t im);
    bit done = 1'b0;
    x_in_re  = re;
    x_in_im  = im;
    in_valid = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (in_ready) begin
        done = 1'b1;
        push_exp(re, im);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check_eq("accept_timeout", bus_t'(in_ready), bus_t'(1));
  endtask

  task automatic wait_valid(input string tag);
    int edges = 0;
    while (out_valid !== 1'b1 && edges < 64) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check_eq(tag, bus_t'(edges), bus_t'(5));
  endtask

  task automatic finish_frame();
    @(posedge clk);
    #1;
    check_eq("consumed", bus_t'(out_valid), bus_t'(0));
  endtask

  task automatic chk_el(input string tag, input bus_t b, input int i, input longint exp);
    check_eq(tag, bus_t'(get_el(b, i)), bus_t'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    longint ovf_exp;
    bus_t   b_re;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_in_re = '0; x_in_im = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", bus_t'(in_ready), bus_t'(0));
    check_eq("rst_out_valid", bus_t'(out_valid), bus_t'(0));
    check_eq("rst_out_re", x_out_re, '0);
    check_eq("rst_out_im", x_out_im, '0);

    // in_valid together with rst must not capture a frame
    in_valid = 1'b1; x_in_re = fill(1000);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("in_ready_after_rst", bus_t'(in_ready), bus_t'(1));
    repeat (8) @(posedge clk);
    #1;
    check_eq("rst_wins_valid", bus_t'(out_valid), bus_t'(0));
    check_eq("rst_wins_data", x_out_re, '0);

    // DC input
    send(fill(1000), '0);
    wait_valid("latency_dc");
    chk_el("dc_re0", x_out_re, 0, 2000);
    chk_el("dc_re7", x_out_re, 7, 2000);
    chk_el("dc_re8", x_out_re, 8, 0);
    chk_el("dc_re15", x_out_re, 15, 0);
    finish_frame();

    // impulse at element 8
    send(put_el('0, 8, 1000), '0);
    wait_valid("latency_imp");
    chk_el("imp_re0", x_out_re, 0, 1000);
    chk_el("imp_re8", x_out_re, 8, -1000);
    chk_el("imp_im8", x_out_im, 8, 0);
    finish_frame();

    // twiddle t=2 (cos/sin of pi/4) and t=4 (-j)
    send(put_el('0, 2, 1000), '0);
    wait_valid("latency_tw2");
    chk_el("tw2_re2", x_out_re, 2, 1000);
    chk_el("tw2_re10", x_out_re, 10, 707);
    chk_el("tw2_im10", x_out_im, 10, -707);
    finish_frame();
    send(put_el('0, 4, 1000), '0);
    wait_valid("latency_tw4");
    chk_el("tw4_re12", x_out_re, 12, 0);
    chk_el("tw4_im12", x_out_im, 12, -1000);
    finish_frame();

    // overflow of the sum path
`ifdef FFT_R2_STAGE_SAT_EN
    ovf_exp = 524287;
`else
    ovf_exp = -2;
`endif
    send(put_el(put_el('0, 0, 524287), 8, 524287), '0);
    wait_valid("latency_ovf");
    chk_el("ovf_re0", x_out_re, 0, ovf_exp);
    chk_el("ovf_re8", x_out_re, 8, 0);
    finish_frame();

    // random full-range frames
    for (int r = 0; r < 3; r++) begin
      send(rnd_bus(), rnd_bus());
      wait_valid("latency_rnd");
      finish_frame();
    end

    // backpressure: frame A held in DONE while frame B waits upstream
    out_ready = 1'b0;
    send(rnd_bus(), rnd_bus());
    wait_valid("latency_bp");
    b_re = rnd_bus();
    x_in_re = b_re; x_in_im = '0; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_re", x_out_re, q_re[0]);
      check_eq("bp_hold_im", x_out_im, q_im[0]);
      check_eq("bp_in_ready", bus_t'(in_ready), bus_t'(0));
      check_eq("bp_out_valid", bus_t'(out_valid), bus_t'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_in_ready_after", bus_t'(in_ready), bus_t'(1));
    check_eq("bp_valid_drop", bus_t'(out_valid), bus_t'(0));
    push_exp(b_re, '0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid("latency_bp2");
    finish_frame();

    // reset during the second RUN cycle discards the frame
    send(rnd_bus(), rnd_bus());
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_valid", bus_t'(out_valid), bus_t'(0));
    check_eq("mid_rst_re", x_out_re, '0);
    check_eq("mid_rst_im", x_out_im, '0);
    check_eq("mid_rst_in_ready", bus_t'(in_ready), bus_t'(0));
    void'(q_re.pop_back());
    void'(q_im.pop_back());
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_rst_ready", bus_t'(in_ready), bus_t'(1));
    send(fill(1000), fill(-300));
    wait_valid("latency_post_rst");
    chk_el("post_rst_re0", x_out_re, 0, 2000);
    chk_el("post_rst_im0", x_out_im, 0, -600);
    finish_frame();

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_drained", bus_t'(q_re.size()), bus_t'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
